// File: rtl/uart_pkg.sv
// Shared constants and type definitions for the UART receive framing block.
package uart_pkg;

    localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
    localparam int unsigned BUF_DEPTH    = 16;
    localparam int unsigned BUF_AW       = 4;
    localparam int unsigned LEN_W        = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_OVERRUN = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

endpackage

// File: rtl/uart_frame_buf.sv
// 16x8 payload buffer: one synchronous write port, one registered read port.
module uart_frame_buf
    import uart_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [BUF_AW-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [BUF_AW-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    logic [7:0] mem_q [BUF_DEPTH];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    // Storage array is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read returns the pre-write contents on a same-address collision.
    always_comb begin
        rd_data_d = mem_q[rd_addr_i];
    end

    // Registered read data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Parses HDR/LEN/payload/checksum frames from a UART byte stream into a held buffer.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEF,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 104160
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_done_i,
    output logic              frame_valid_o,
    output logic [LEN_W-1:0]  frame_len_o,
    input  logic              frame_ack_i,
    input  logic [BUF_AW-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              frame_err_o,
    output logic [1:0]        err_code_o
);

    localparam int unsigned      TO_W      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    logic [1:0]       rst_sync_q;
    logic             rst_n;

    state_e           state_q,    state_d;
    logic [LEN_W-1:0] idx_q,      idx_d;
    logic [LEN_W-1:0] len_q,      len_d;
    logic [7:0]       sum_q,      sum_d;
    logic [TO_W-1:0]  to_cnt_q,   to_cnt_d;
    logic             valid_q,    valid_d;
    logic             err_q,      err_d;
    err_code_e        err_code_q, err_code_d;
    logic             buf_wr_en;
    logic             hdr_hit;

    // Async assert, clock-synchronised release of the internal reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n   = rst_sync_q[1];
    assign hdr_hit = rx_done_i && (rx_data_i == HDR_BYTE);

    // Next-state, datapath and error decisions.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        sum_d      = sum_q;
        to_cnt_d   = to_cnt_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        buf_wr_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hdr_hit) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_done_i) begin
                    if ((rx_data_i != 8'd0) && (rx_data_i <= MAX_LEN_B)) begin
                        len_d   = LEN_W'(rx_data_i);
                        sum_d   = rx_data_i;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_LEN;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (rx_done_i) begin
                    buf_wr_en = 1'b1;
                    sum_d     = sum_q + rx_data_i;
                    idx_d     = idx_q + LEN_W'(1);
                    if (idx_d == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_done_i) begin
                    if (rx_data_i == sum_q) begin
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_ack_i) begin
                    valid_d = 1'b0;
                    state_d = hdr_hit ? ST_LEN : ST_IDLE;
                end else if (rx_done_i) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Inter-byte timeout while a frame is in progress; a byte beats expiry.
        if ((state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM)) begin
            if (rx_done_i) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                to_cnt_d   = '0;
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
                state_d    = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            to_cnt_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_OVERRUN;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            to_cnt_q   <= to_cnt_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    uart_frame_buf u_buf (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n),
        .wr_en_i   (buf_wr_en),
        .wr_addr_i (idx_q[BUF_AW-1:0]),
        .wr_data_i (rx_data_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o)
    );

    assign frame_valid_o = valid_q;
    assign frame_len_o   = len_q;
    assign frame_err_o   = err_q;
    assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomised frame-level bench for uart_rx_frame_ctrl with a transaction reference model.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned T   = 50;
    localparam logic [7:0]  HDR = 8'hA5;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] rx_data_i;
    logic       rx_done_i;
    logic       frame_valid_o;
    logic [4:0] frame_len_o;
    logic       frame_ack_i;
    logic [3:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;

    int n_cmp = 0;
    int n_bad = 0;
    int err_q[$];

    // Current frame description consumed by run_frame / hold_phase.
    logic [7:0] f_len;
    logic [7:0] f_pay [16];
    logic [7:0] f_csum_xor;
    int         f_gap_pos;
    int         f_gap_len;
    bit         held;

    uart_rx_frame_ctrl #(
        .HDR_BYTE     (HDR),
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .rx_data_i     (rx_data_i),
        .rx_done_i     (rx_done_i),
        .frame_valid_o (frame_valid_o),
        .frame_len_o   (frame_len_o),
        .frame_ack_i   (frame_ack_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .frame_err_o   (frame_err_o),
        .err_code_o    (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    // Collect every error strobe with its code.
    always @(negedge clk_i) begin
        if (rst_n_i && frame_err_o) begin
            err_q.push_back(int'(err_code_o));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        rx_data_i   = b;
        rx_done_i   = 1'b1;
        frame_ack_i = ack;
        @(posedge clk_i);
        #1;
        rx_done_i   = 1'b0;
        frame_ack_i = 1'b0;
    endtask

    task automatic expect_err(input string tag, input int n, input int code);
        idle(2);
        check_eq({tag, " err_count"}, err_q.size(), n);
        for (int i = 0; i < err_q.size(); i++) begin
            check_eq({tag, " err_code"}, err_q[i], code);
        end
        err_q.delete();
    endtask

    task automatic random_payload();
        for (int i = 0; i < 16; i++) f_pay[i] = 8'($urandom);
    endtask

    // Send optional garbage then one frame; predict the outcome from the frame rules.
    task automatic run_frame(input string tag, input int n_garbage, output bit hold);
        logic [7:0] seq[$];
        logic [7:0] sum;
        logic [7:0] b;
        bit         len_ok;
        bit         timed_out;
        int         g;
        timed_out = 1'b0;
        for (int i = 0; i < n_garbage; i++) begin
            b = 8'($urandom);
            if (b == HDR) b = 8'h00;
            send_byte(b, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        if (n_garbage > 0) expect_err({tag, " garbage"}, 0, 0);
        len_ok = (f_len >= 8'd1) && (f_len <= 8'd16);
        seq.push_back(HDR);
        seq.push_back(f_len);
        sum = f_len;
        if (len_ok) begin
            for (int i = 0; i < int'(f_len); i++) begin
                seq.push_back(f_pay[i]);
                sum = sum + f_pay[i];
            end
            seq.push_back(sum ^ f_csum_xor);
        end
        for (int k = 0; k < seq.size(); k++) begin
            send_byte(seq[k], 1'b0);
            if (k == seq.size() - 1) break;
            g = (k == f_gap_pos) ? f_gap_len : int'($urandom_range(0, 4));
            idle(g);
            if (g >= int'(T)) begin
                timed_out = 1'b1;
                break;
            end
        end
        hold = 1'b0;
        if (timed_out) begin
            idle(int'(T) + 5);
            expect_err({tag, " timeout"}, 1, 3);
        end else if (!len_ok) begin
            expect_err({tag, " badlen"}, 1, 1);
        end else if (f_csum_xor != 8'h00) begin
            expect_err({tag, " csum"}, 1, 2);
        end else begin
            expect_err({tag, " good"}, 0, 0);
            hold = 1'b1;
        end
        check_eq({tag, " valid"}, frame_valid_o, hold);
        if (hold) check_eq({tag, " len"}, frame_len_o, f_len);
    endtask

    // Overrun bytes, payload readback, then release with one of three ack styles.
    task automatic hold_phase(input string tag, input int n_ovr, input int ack_mode);
        logic [7:0] b;
        for (int i = 0; i < n_ovr; i++) begin
            send_byte(8'($urandom), 1'b0);
            expect_err({tag, " overrun"}, 1, 0);
            check_eq({tag, " ovr valid"}, frame_valid_o, 1);
            check_eq({tag, " ovr len"}, frame_len_o, f_len);
        end
        for (int a = 0; a < int'(f_len); a++) begin
            rd_addr_i = 4'(a);
            idle(1);
            check_eq({tag, " rd_data"}, rd_data_o, f_pay[a]);
        end
        case (ack_mode)
            0: begin
                frame_ack_i = 1'b1;
                idle(1);
                frame_ack_i = 1'b0;
                expect_err({tag, " ack"}, 0, 0);
                check_eq({tag, " ack valid"}, frame_valid_o, 0);
            end
            1: begin
                send_byte(HDR, 1'b1);
                expect_err({tag, " ack+hdr"}, 0, 0);
                check_eq({tag, " ack+hdr valid"}, frame_valid_o, 0);
                send_byte(8'h00, 1'b0);
                expect_err({tag, " ack+hdr in LEN"}, 1, 1);
            end
            default: begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h5A;
                send_byte(b, 1'b1);
                expect_err({tag, " ack+byte"}, 0, 0);
                check_eq({tag, " ack+byte valid"}, frame_valid_o, 0);
            end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " valid"}, frame_valid_o, 0);
        check_eq({tag, " len"}, frame_len_o, 0);
        check_eq({tag, " err"}, frame_err_o, 0);
        check_eq({tag, " err_code"}, err_code_o, 0);
        check_eq({tag, " rd_data"}, rd_data_o, 0);
    endtask

    initial begin
        int r;
        rst_n_i     = 1'b0;
        rx_data_i   = 8'h00;
        rx_done_i   = 1'b0;
        frame_ack_i = 1'b0;
        rd_addr_i   = 4'd0;
        f_gap_pos   = -1;
        f_gap_len   = 0;
        f_csum_xor  = 8'h00;
        #3;
        check_all_zero("reset");
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        idle(4);

        // Good frame A5 03 11 22 33 69.
        f_len = 8'd3; f_pay[0] = 8'h11; f_pay[1] = 8'h22; f_pay[2] = 8'h33;
        run_frame("good", 0, held);
        if (held) hold_phase("good", 0, 0);

        // Checksum error A5 02 10 20 31 (correct sum is 32).
        f_len = 8'd2; f_pay[0] = 8'h10; f_pay[1] = 8'h20; f_csum_xor = 8'h03;
        run_frame("csum", 0, held);
        f_csum_xor = 8'h00;

        // Bad lengths 0 and 17, then a good frame.
        f_len = 8'd0;  run_frame("len0", 0, held);
        f_len = 8'h11; run_frame("len17", 0, held);
        f_len = 8'd5; random_payload();
        run_frame("after_badlen", 1, held);
        if (held) hold_phase("after_badlen", 0, 0);

        // Timeout after A5 02 10, then a byte landing exactly on the expiry cycle.
        f_len = 8'd2; f_pay[0] = 8'h10; f_pay[1] = 8'h20;
        f_gap_pos = 2; f_gap_len = int'(T) + 5;
        run_frame("timeout", 0, held);
        f_gap_len = int'(T) - 1;
        run_frame("expiry_byte", 0, held);
        if (held) hold_phase("expiry_byte", 0, 0);
        f_gap_pos = -1;

        // Overrun in HOLD, then ack coincident with A5.
        f_len = 8'd16; random_payload();
        run_frame("overrun", 0, held);
        if (held) hold_phase("overrun", 2, 1);

        // Reset mid-DATA.
        rd_addr_i = 4'd0;
        send_byte(HDR, 1'b0);
        send_byte(8'd3, 1'b0);
        send_byte(8'h11, 1'b0);
        idle(1);
        check_eq("pre_reset rd_data", rd_data_o, 8'h11);
        rst_n_i = 1'b0;
        #1;
        check_all_zero("mid_reset");
        idle(3);
        rst_n_i = 1'b1;
        idle(4);
        expect_err("post_reset", 0, 0);
        f_len = 8'd4; random_payload();
        run_frame("post_reset", 0, held);
        if (held) hold_phase("post_reset", 0, 0);

        // Randomised frames.
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      f_len = 8'd0;
            else if (r == 1) f_len = 8'($urandom_range(17, 255));
            else             f_len = 8'($urandom_range(1, 16));
            random_payload();
            f_csum_xor = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if ($urandom_range(0, 5) == 0) begin
                f_gap_pos = ((f_len >= 8'd1) && (f_len <= 8'd16)) ?
                            int'($urandom_range(0, int'(f_len) + 1)) : 0;
                f_gap_len = ($urandom_range(0, 1) == 0) ? int'(T) - 1
                                                        : int'(T) + int'($urandom_range(0, 3));
            end else begin
                f_gap_pos = -1;
            end
            run_frame("rand", int'($urandom_range(0, 2)), held);
            if (held) hold_phase("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
